// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared types and constants for the host command engine
//
// Purpose : command ids, FSM state encoding, register indices and the
//           header-size helper shared by cmd_engine and cmd_hdr_shift.
// Ports   : none (package)
package cmd_pkg;

  typedef enum logic [3:0] {
    CMD_RESET  = 4'd0,
    CMD_MEM_RD = 4'd1,
    CMD_MEM_WR = 4'd2,
    CMD_REG_RD = 4'd3,
    CMD_REG_WR = 4'd4
  } cmd_id_e;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_DECODE,
    S_RESET,
    S_RD_REQ,
    S_RD_SEND,
    S_WR,
    S_RSP
  } cmd_state_e;

  // Header carries a 4-bit id plus address and count fields of addr_bits each.
  function automatic int hdr_bytes(input int addr_bits);
    return (4 + 2 * addr_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/cmd_hdr_shift.sv
// rtl/cmd_hdr_shift.sv - little-endian header byte shift-in with byte counter
//
// Purpose : collects HDR_BYTES accepted bytes, first byte ends up in bits [7:0].
// Ports   : clk_i, rst_i        clock, synchronous active-high reset
//           byte_valid_i       a header byte is accepted this cycle
//           byte_data_i[7:0]   the accepted byte
//           hdr_o              assembled header (complete the cycle after hdr_valid_o)
//           hdr_valid_o        pulses with the final header byte's accept
module cmd_hdr_shift #(
  parameter int HDR_BYTES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  output logic [HDR_BYTES*8-1:0] hdr_o,
  output logic                   hdr_valid_o
);

  localparam int HW = HDR_BYTES * 8;
  localparam int CW = $clog2(HDR_BYTES);

  logic [HW-1:0] hdr_q, hdr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = byte_valid_i && (cnt_q == CW'(HDR_BYTES - 1));

  always_comb begin
    hdr_d = hdr_q;
    cnt_d = cnt_q;
    if (byte_valid_i) begin
      // New bytes enter at the top so the first byte lands at the bottom.
      hdr_d = {byte_data_i, hdr_q[HW-1:8]};
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_q <= '0;
      cnt_q <= '0;
    end else begin
      hdr_q <= hdr_d;
      cnt_q <= cnt_d;
    end
  end

  assign hdr_o       = hdr_q;
  assign hdr_valid_o = last;

endmodule

// File: rtl/cmd_engine.sv
// rtl/cmd_engine.sv - host command engine: header decode, memory moves, register file
//
// Purpose : consumes a host byte stream, decodes LE headers and runs RESET,
//           MEM_RD, MEM_WR, REG_RD and REG_WR commands; stalls on backpressure.
// Ports   : i_clk, i_rst                         clock, synchronous active-high reset
//           i_in_valid/i_in_data/o_in_ready      host byte stream in
//           o_out_valid/o_out_data/i_out_ready   response byte stream out
//           o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata  byte memory port
//           o_cpu_en, i_cpu_halted               CPU control/status
//           o_dev_rst                            device reset pulse
module cmd_engine
  import cmd_pkg::*;
#(
  parameter int         ADDR_BITS  = 14,
  parameter int         NUM_REGS   = 4,
  parameter int         RST_CYCLES = 4,
  parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  input  logic [7:0]           i_in_data,
  output logic                 o_in_ready,
  output logic                 o_out_valid,
  output logic [7:0]           o_out_data,
  input  logic                 i_out_ready,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [7:0]           o_mem_wdata,
  input  logic [7:0]           i_mem_rdata,
  output logic                 o_cpu_en,
  input  logic                 i_cpu_halted,
  output logic                 o_dev_rst
);

  localparam int HDR_BYTES = hdr_bytes(ADDR_BITS);
  localparam int HW        = HDR_BYTES * 8;
  localparam int RIW       = $clog2(NUM_REGS);
  localparam int RCW       = $clog2(RST_CYCLES + 1);

  localparam logic [RIW-1:0]       CTRL_IDX   = RIW'(REG_CTRL);
  localparam logic [ADDR_BITS-1:0] STATUS_ADR = ADDR_BITS'(REG_STATUS);
  localparam logic [ADDR_BITS:0]   NUM_REGS_W = (ADDR_BITS + 1)'(NUM_REGS);

  cmd_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] remain_q, remain_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 first_q, first_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [7:0]           regs_q [NUM_REGS];
  logic [7:0]           regs_d [NUM_REGS];

  logic [HW-1:0]        hdr;
  logic                 hdr_valid;
  logic                 in_ready;
  logic                 in_accept;
  logic [3:0]           hdr_id;
  logic [ADDR_BITS-1:0] hdr_addr;
  logic [ADDR_BITS-1:0] hdr_count;
  logic                 addr_in_range;
  logic [7:0]           reg_rd_data;
  logic                 reg_wr_en;
  logic                 clr_cpu;

  // Ready is a pure function of state so the accept path has no loop through the FSM.
  assign in_ready   = !i_rst && (state_q == S_HDR || state_q == S_WR);
  assign in_accept  = i_in_valid && in_ready;
  assign o_in_ready = in_ready;

  cmd_hdr_shift #(
    .HDR_BYTES (HDR_BYTES)
  ) u_hdr_shift (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .byte_valid_i (in_accept && state_q == S_HDR),
    .byte_data_i  (i_in_data),
    .hdr_o        (hdr),
    .hdr_valid_o  (hdr_valid)
  );

  assign hdr_id    = hdr[2*ADDR_BITS+3 : 2*ADDR_BITS];
  assign hdr_addr  = hdr[2*ADDR_BITS-1 : ADDR_BITS];
  assign hdr_count = hdr[ADDR_BITS-1 : 0];

  assign addr_in_range = ({1'b0, hdr_addr} < NUM_REGS_W);

  always_comb begin
    reg_rd_data = 8'h00;
    if (hdr_addr == STATUS_ADR) begin
      reg_rd_data = {6'b0, i_cpu_halted, regs_q[CTRL_IDX][0]};
    end else if (addr_in_range) begin
      reg_rd_data = regs_q[hdr_addr[RIW-1:0]];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    out_data_d  = out_data_q;
    first_d     = 1'b0;
    rst_cnt_d   = rst_cnt_q;
    reg_wr_en   = 1'b0;
    clr_cpu     = 1'b0;
    o_out_valid = 1'b0;
    o_out_data  = out_data_q;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = 8'h00;
    o_dev_rst   = 1'b0;

    case (state_q)
      S_HDR: begin
        if (hdr_valid) state_d = S_DECODE;
      end

      S_DECODE: begin
        addr_d   = hdr_addr;
        remain_d = hdr_count;
        case (hdr_id)
          CMD_RESET: begin
            rst_cnt_d = RCW'(RST_CYCLES - 1);
            state_d   = S_RESET;
          end
          CMD_MEM_RD: state_d = S_RD_REQ;
          CMD_MEM_WR: state_d = S_WR;
          CMD_REG_RD: begin
            out_data_d = reg_rd_data;
            state_d    = S_RSP;
          end
          CMD_REG_WR: begin
            reg_wr_en = 1'b1;
            state_d   = S_HDR;
          end
          default: begin
            out_data_d = ERR_BYTE;
            state_d    = S_RSP;
          end
        endcase
      end

      S_RESET: begin
        o_dev_rst = 1'b1;
        clr_cpu   = 1'b1;
        if (rst_cnt_q == '0) state_d = S_HDR;
        else                 rst_cnt_d = rst_cnt_q - 1'b1;
      end

      S_RD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = addr_q;
        first_d    = 1'b1;
        state_d    = S_RD_SEND;
      end

      S_RD_SEND: begin
        o_out_valid = 1'b1;
        // Read data is only valid in the first SEND cycle; present it directly
        // and latch it so it stays stable under backpressure.
        if (first_q) begin
          o_out_data = i_mem_rdata;
          out_data_d = i_mem_rdata;
        end
        if (i_out_ready) begin
          if (remain_q == '0) begin
            state_d = S_HDR;
          end else begin
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            state_d  = S_RD_REQ;
          end
        end
      end

      S_WR: begin
        if (in_accept) begin
          o_mem_req   = 1'b1;
          o_mem_we    = 1'b1;
          o_mem_addr  = addr_q;
          o_mem_wdata = i_in_data;
          if (remain_q == '0) begin
            state_d = S_HDR;
          end else begin
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
          end
        end
      end

      S_RSP: begin
        o_out_valid = 1'b1;
        if (i_out_ready) state_d = S_HDR;
      end

      default: state_d = S_HDR;
    endcase

    // Reset cycle drives every output quiet, dropping any pending response.
    if (i_rst) begin
      o_out_valid = 1'b0;
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = 8'h00;
      o_dev_rst   = 1'b0;
    end
  end

  // Later assignments take priority: auto-clear, then RESET, then REG_WR.
  always_comb begin
    regs_d = regs_q;
    if (regs_q[CTRL_IDX][0] && i_cpu_halted) regs_d[CTRL_IDX][0] = 1'b0;
    if (clr_cpu) regs_d[CTRL_IDX][0] = 1'b0;
    if (reg_wr_en && addr_in_range && hdr_addr != STATUS_ADR) begin
      regs_d[hdr_addr[RIW-1:0]] = hdr_count[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_HDR;
      addr_q     <= '0;
      remain_q   <= '0;
      out_data_q <= 8'h00;
      first_q    <= 1'b0;
      rst_cnt_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      out_data_q <= out_data_d;
      first_q    <= first_d;
      rst_cnt_q  <= rst_cnt_d;
      regs_q     <= regs_d;
    end
  end

  assign o_cpu_en = regs_q[CTRL_IDX][0];

endmodule

// File: tb/tb_cmd_engine.sv
// tb/tb_cmd_engine.sv - directed scoreboard bench for cmd_engine
module tb_cmd_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cpu_en;
  logic        cpu_halted;
  logic        dev_rst;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_count = 0;
  int we_count = 0;

  logic [7:0]  exp_q [$];
  logic [21:0] wexp_q [$];
  logic [7:0]  mem [16384];

  cmd_engine dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .i_out_ready  (out_ready),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_cpu_en     (cpu_en),
    .i_cpu_halted (cpu_halted),
    .o_dev_rst    (dev_rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-wide memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_req && !mem_we) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard monitor, sampled at negedge ahead of the handshake edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      rx_count++;
      chk("out_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
    end
    if (mem_req && mem_we) begin
      we_count++;
      chk("wr_pending", wexp_q.size() > 0, 1);
      if (wexp_q.size() > 0) chk("wr_addr_data", {mem_addr, mem_wdata}, wexp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   c;
    acc = 1'b0;
    c   = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && c < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      c++;
    end
    in_valid = 1'b0;
    if (!acc) chk("in_accept_timeout", acc, 1);
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      tick(1);
      c++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    @(negedge clk);
    while (!out_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk(tag, out_valid, 1);
  endtask

  initial begin
    logic [7:0] hold_d;
    logic       stable;
    int         base;
    int         c;
    int         rst_hi;

    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem_rdata  = 8'h00;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b1;
    cpu_halted = 1'b0;

    // Reset state
    tick(2);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_outputs", {out_valid, mem_req, mem_we, cpu_en, dev_rst}, 5'b0);
    tick(1);

    // Memory write of three bytes at 0x10
    wexp_q.push_back({14'h0010, 8'hAA});
    wexp_q.push_back({14'h0011, 8'hBB});
    wexp_q.push_back({14'h0012, 8'hCC});
    send4(32'h2004_0002);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    tick(3);
    chk("wr_we_pulses", we_count, 3);
    chk("wr_mem_10", mem[14'h10], 8'hAA);
    chk("wr_mem_12", mem[14'h12], 8'hCC);

    // Read back with ready held high
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    send4(32'h1004_0002);
    drain("rd_drain");
    tick(3);
    chk("rd_no_extra", out_valid, 0);

    // Backpressure after the first byte of a read
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    base = rx_count;
    send4(32'h1004_0002);
    c = 0;
    while (rx_count != base + 1 && c < 100) begin
      tick(1);
      c++;
    end
    chk("bp_first_byte", rx_count, base + 1);
    out_ready = 1'b0;
    wait_valid("bp_valid");
    hold_d = out_data;
    chk("bp_hold_data", hold_d, 8'hBB);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (!(out_valid && out_data == hold_d)) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    tick(1);
    out_ready = 1'b1;
    drain("bp_drain");
    tick(3);
    chk("bp_count", rx_count, base + 3);

    // Wrapping write across the top of memory
    wexp_q.push_back({14'h3FFF, 8'h11});
    wexp_q.push_back({14'h0000, 8'h22});
    send4(32'h2FFF_C001);
    send_byte(8'h11);
    send_byte(8'h22);
    tick(3);
    chk("wrap_mem_top", mem[14'h3FFF], 8'h11);
    chk("wrap_mem_zero", mem[14'h0000], 8'h22);

    // Register file
    send4(32'h4000_0001);
    tick(3);
    chk("reg_cpu_en_set", cpu_en, 1);
    exp_q.push_back(8'h01);
    send4(32'h3000_4000);
    drain("reg_status_en");

    cpu_halted = 1'b1;
    @(negedge clk);
    chk("halt_before_clear", cpu_en, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("halt_auto_clear", cpu_en, 0);
    tick(1);
    exp_q.push_back(8'h02);
    send4(32'h3000_4000);
    drain("reg_status_halt");
    cpu_halted = 1'b0;

    send4(32'h4000_80A5);
    tick(2);
    exp_q.push_back(8'hA5);
    send4(32'h3000_8000);
    drain("reg_scratch");
    exp_q.push_back(8'h00);
    send4(32'h3001_4000);
    drain("reg_out_of_range");
    send4(32'h4000_40FF);
    tick(2);
    exp_q.push_back(8'h00);
    send4(32'h3000_4000);
    drain("reg_status_ro");

    // Unknown command id
    exp_q.push_back(8'hEE);
    send4(32'hF000_0000);
    drain("err_byte");

    // RESET command
    send4(32'h4000_0001);
    tick(3);
    chk("pre_reset_cpu_en", cpu_en, 1);
    send4(32'h0000_0000);
    rst_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dev_rst) rst_hi++;
    end
    chk("dev_rst_cycles", rst_hi, 4);
    chk("reset_cpu_en", cpu_en, 0);
    tick(1);

    // i_rst in the middle of a stalled read
    out_ready = 1'b0;
    send4(32'h1004_0002);
    wait_valid("mid_rst_valid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_drop", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {out_valid, in_ready}, 2'b01);
    tick(1);
    out_ready = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send4(32'h1FFF_C001);
    drain("post_rst_wrap_read");

    tick(5);
    chk("out_queue_empty", exp_q.size(), 0);
    chk("wr_queue_empty", wexp_q.size(), 0);
    chk("total_we_pulses", we_count, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
